// File: rtl/fifo_rd_stream_adapter.sv
// Read-side FIFO adapter: drains a one-cycle-latency FIFO port into
// a valid/ready stream through a 3-entry credit-limited buffer.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0] head;
  logic [1:0] tail;
  logic [1:0] count;
  logic       inflight;
  logic       pop;
  logic [2:0] credit_used;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Credits count both buffered words and the one still in the FIFO pipe
  assign credit_used = {1'b0, count} + {2'b0, inflight};
  assign fifo_rd_en  = !reset && enable && !fifo_empty
                     && (credit_used < 3'd3);

  assign m_valid = (count != 2'd0);
  assign m_data  = mem[head];
  assign pop     = m_valid && m_ready;
  assign busy    = m_valid || inflight;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      head       <= 2'd0;
      tail       <= 2'd0;
      count      <= 2'd0;
      inflight   <= 1'b0;
      word_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        mem[tail] <= fifo_dout;
        tail      <= nxt(tail);
      end
      if (pop) begin
        head       <= nxt(head);
        word_count <= word_count + CNT_WIDTH'(1);
      end
      unique case ({inflight, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge rd_clk) begin
    if (!reset && inflight && !pop)
      assert (count != 2'd3);
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Randomized bench for fifo_rd_stream_adapter with a queue-based
// reference model and an attached FIFO model with one-cycle latency.
module tb_fifo_rd_stream_adapter;

  logic       rd_clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       m_ready;

  logic        fifo_rd_en, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] word_count;
  logic        rd_en4, valid4, busy4;
  logic [7:0]  data4;
  logic [3:0]  wc4;

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rd_clk(rd_clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .word_count(word_count), .busy(busy)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .rd_clk(rd_clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(rd_en4), .m_valid(valid4), .m_data(data4),
    .m_ready(m_ready), .word_count(wc4), .busy(busy4)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] mq[$];
  bit         m_infl;
  int         wc;

  int rd_cnt, valid_cnt, run, max_run;
  int first_rd, first_valid, cyc;
  logic [7:0] first_data;
  logic [7:0] dq[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    rd_cnt = 0; valid_cnt = 0; run = 0; max_run = 0;
    first_rd = -1; first_valid = -1; cyc = 0;
    first_data = 8'h00;
    dq.delete();
  endtask

  task automatic tick();
    bit exp_rd, exp_v, pop_m, rd_d;
    logic [7:0] capt;
    @(negedge rd_clk);
    exp_rd = !reset && enable && !fifo_empty
           && (mq.size() + int'(m_infl) < 3);
    exp_v = (mq.size() != 0);
    check("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
    check("rd_en_w4", {31'd0, rd_en4}, {31'd0, exp_rd});
    check("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
    if (exp_v) check("m_data", {24'd0, m_data}, {24'd0, mq[0]});
    check("busy", {31'd0, busy}, {31'd0, exp_v || m_infl});
    check("word_count", {16'd0, word_count}, wc & 32'hFFFF);
    check("word_count_w4", {28'd0, wc4}, wc & 32'hF);
    rd_d = fifo_rd_en;
    if (rd_d) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid) begin
      valid_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (first_valid < 0) begin
        first_valid = cyc;
        first_data = m_data;
      end
      if (m_ready) dq.push_back(m_data);
    end else run = 0;
    pop_m = exp_v && m_ready;
    capt = fifo_dout;
    @(posedge rd_clk);
    #1;
    cyc++;
    if (reset) begin
      mq.delete(); m_infl = 0; wc = 0;
      q.delete(); fifo_dout = 8'h00;
    end else begin
      if (pop_m) begin
        void'(mq.pop_front());
        wc++;
      end
      if (m_infl) mq.push_back(capt);
      m_infl = exp_rd;
      if (rd_d && q.size() != 0) fifo_dout = q.pop_front();
      else fifo_dout = 8'($urandom);
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    mq.delete(); m_infl = 0; wc = 0;
    q.delete(); fifo_dout = 8'h00; fifo_empty = 1'b1;
    tick(); tick();
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic load_seq(input int n);
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    fifo_empty = (q.size() == 0);
  endtask

  task automatic check_order(input string nm, input int n);
    check({nm, "_len"}, dq.size(), n);
    for (int i = 0; i < n && i < dq.size(); i++)
      check(nm, {24'd0, dq[i]}, i);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; m_ready = 1'b0;
    fifo_empty = 1'b1; fifo_dout = 8'h00;
    mq.delete(); m_infl = 0; wc = 0;
    clear_stats();
    #2;
    check("reset_valid", {31'd0, m_valid}, 0);
    check("reset_data", {24'd0, m_data}, 0);
    do_reset();

    // single word
    q.push_back(8'hA5); fifo_empty = 1'b0;
    enable = 1'b1; m_ready = 1'b1;
    repeat (6) tick();
    check("single_rd_pulses", rd_cnt, 1);
    check("single_valid_cycles", valid_cnt, 1);
    check("single_latency", first_valid - first_rd, 2);
    check("single_data", {24'd0, first_data}, 32'hA5);
    check("single_wc", {16'd0, word_count}, 1);

    // streaming
    do_reset();
    load_seq(16);
    enable = 1'b1; m_ready = 1'b1;
    repeat (22) tick();
    check("stream_run", max_run, 16);
    check("stream_valid", valid_cnt, 16);
    check_order("stream_order", 16);
    check("stream_wc", {16'd0, word_count}, 16);
    check("stream_busy", {31'd0, busy}, 0);

    // reset mid-stream: 2 buffered, 1 in flight
    load_seq(8);
    m_ready = 1'b0;
    repeat (3) tick();
    check("pre_reset_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    check("rst_valid", {31'd0, m_valid}, 0);
    check("rst_data", {24'd0, m_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_wc", {16'd0, word_count}, 0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 0);
    mq.delete(); m_infl = 0; wc = 0;
    q.delete(); fifo_empty = 1'b1; fifo_dout = 8'h00;
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_valid", {31'd0, m_valid}, 0);
    check("post_rst_data", {24'd0, m_data}, 0);
    check("post_rst_busy", {31'd0, busy}, 0);
    check("post_rst_rd_en", {31'd0, fifo_rd_en}, 0);

    // backpressure
    do_reset();
    load_seq(16);
    enable = 1'b1; m_ready = 1'b0;
    repeat (10) tick();
    check("bp_rd_pulses", rd_cnt, 3);
    check("bp_valid", {31'd0, m_valid}, 1);
    check("bp_data_held", {24'd0, m_data}, 0);
    for (int i = 0; i < 300 && dq.size() < 16; i++) begin
      m_ready = 1'($urandom);
      tick();
    end
    m_ready = 1'b1;
    repeat (4) tick();
    check_order("bp_order", 16);

    // enable drop with a read in flight
    do_reset();
    load_seq(8);
    enable = 1'b1; m_ready = 1'b1;
    tick();
    check("en_first_rd", rd_cnt, 1);
    enable = 1'b0;
    rd_cnt = 0;
    repeat (5) tick();
    check("en_off_reads", rd_cnt, 0);
    check("en_off_delivered", dq.size(), 1);
    enable = 1'b1;
    run = 0; max_run = 0;
    repeat (15) tick();
    check("en_resume_run", max_run, 7);
    check_order("en_order", 8);

    // counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
    fifo_empty = 1'b0;
    enable = 1'b1; m_ready = 1'b1;
    repeat (25) tick();
    check("wrap_wc4", {28'd0, wc4}, 1);
    check("wrap_wc16", {16'd0, word_count}, 17);

    // random soak
    do_reset();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      m_ready = 1'($urandom);
      if ($urandom_range(0, 9) < 6) q.push_back(8'($urandom));
      fifo_empty = (q.size() == 0);
      tick();
    end
    enable = 1'b0; m_ready = 1'b1;
    repeat (8) tick();
    check("soak_drained", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream_adapter.md
# fifo_rd_stream_adapter

Read-side adapter that drains a FIFO with a registered one-cycle read latency and presents the data as a valid/ready stream. It sits in the read clock domain, behind the asynchronous FIFO's `empty`/`rd_en`/`dout` port, and feeds downstream consumers that may apply backpressure. A 3-entry output buffer gives sustained one-word-per-cycle throughput. `fifo_rd_en` does not depend combinationally on `m_ready`.

## Interface
- `DATA_WIDTH`, default 8: width of the FIFO data word and stream data.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

- `rd_clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: reset, asynchronous and active-high.
- `enable` input 1: permits new FIFO reads; buffered data drains regardless.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_dout` input DATA_WIDTH: FIFO read data, valid the cycle after an accepted read.
- `fifo_rd_en` output 1: FIFO read strobe.
- `m_valid` output 1: stream data valid.
- `m_data` output DATA_WIDTH: stream data.
- `m_ready` input 1: downstream accepts data.
- `word_count` output CNT_WIDTH: number of stream transfers completed (wraps).
- `busy` output 1: data is buffered or a read is in flight.

## Operation
- **State:**
  - 3-entry buffer `buf[0..2]` with 2-bit head and tail indices, each wrapping 2→0.
  - `count` (0..3).
  - `inflight` flag.
  - `word_count`.
- **Read issue:** `fifo_rd_en = enable && !fifo_empty && (count + inflight) < 3`.
  - Combinational from registered state and inputs only.
  - Forced to 0 while `reset` is asserted.
- **Capture:**
  - `inflight <= fifo_rd_en` every cycle.
  - When `inflight` is 1, `fifo_dout` is written to `buf[tail]` and `tail` advances. This is the push.
- **Output:**
  - `m_valid = (count != 0)`.
  - `m_data = buf[head]`.
  - The pop is `m_valid && m_ready`; `head` advances on a pop.
- **Count update:**
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged.
- The credit rule guarantees a push never finds `count` = 3. An implementation may flag an overflow assertion in simulation.
- **word_count:** +1 on each pop, modulo 2^CNT_WIDTH.
- **busy:** `(count != 0) || inflight`.
- **Order:** data leaves in exactly the order it was read from the FIFO; no word is dropped or duplicated.
- **enable:**
  - Deasserting `enable` stops new reads only.
  - An in-flight word is still captured, and buffered words still drain.
  - Re-asserting resumes reads with no state loss.
- **Stream rules:**
  - `m_data` holds stable while `m_valid` is high and `m_ready` is low.
  - `m_valid` never drops without a pop.
- **Reset (asynchronous, any time):** all of the following clear to 0 at once:
  - `count`, `inflight`, `head`, `tail`, the buffer contents, `word_count`.
  - Hence `m_valid`, `m_data`, `busy`, `fifo_rd_en`.
  - An in-flight word at reset is discarded. The FIFO is expected to be reset on the same event.

## Timing
- **Latency:**
  - Cycle N: `fifo_rd_en` = 1.
  - Cycle N+1: `fifo_dout` is valid and is captured at the end of the cycle.
  - Cycle N+2: `m_valid` = 1.
  - From `fifo_empty` falling (with `enable` = 1 and the buffer empty) to `m_valid` is 2 cycles.
- **Throughput:** 1 word per cycle sustained with `m_ready` held at 1 and the FIFO non-empty.
  - In steady state `count` = 1 and `inflight` = 1, so reads issue every cycle.
- **Backpressure:** with `m_ready` = 0, at most 3 words are buffered, and `fifo_rd_en` stays 0 while `count + inflight` = 3.
  - The first pop after `m_ready` rises frees a credit. The read is reissued in the following cycle, because issue depends on registered `count`.
- `fifo_empty` is sampled only in the issue cycle. The FIFO guarantees that a read issued while non-empty returns data.

## Test plan
- **Reset values:** assert `reset` mid-stream with 2 words buffered and 1 in flight → immediately `m_valid` = 0, `m_data` = 0, `busy` = 0, `word_count` = 0, `fifo_rd_en` = 0. After release with the FIFO empty, outputs stay 0.
- **Single word:** FIFO holds 0xA5, `enable` = 1, `m_ready` = 1 → `fifo_rd_en` pulses 1 cycle, `m_valid` = 1 with `m_data` = 0xA5 exactly 2 cycles later for 1 cycle, then `word_count` = 1.
- **Streaming:** FIFO preloaded with 0x00..0x0F, `m_ready` = 1 → 16 consecutive `m_valid` cycles carrying 0x00..0x0F in order, then `word_count` = 16 and `busy` = 0.
- **Backpressure:** same preload with `m_ready` = 0 for 10 cycles → exactly 3 `fifo_rd_en` pulses, `m_data` held at 0x00. Then toggle `m_ready` randomly → all 16 words delivered in order, none lost or duplicated.
- **Enable drop with a read in flight:** deassert `enable` in the cycle after a `fifo_rd_en` → that word is still delivered, no further reads occur. Re-enable → reads resume and the sequence continues without a gap.
- **Counter wrap:** with `CNT_WIDTH` = 4, deliver 17 words → `word_count` = 1.
